// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared width/state encodings for the data-memory access path
package dmem_pkg;

    localparam logic [1:0] WIDTH_WORD = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Reserved width 2'b11 falls into the word rule.
    function automatic logic misaligned(input logic [1:0] width, input logic [1:0] offset);
        case (width)
            WIDTH_BYTE: misaligned = 1'b0;
            WIDTH_HALF: misaligned = offset[0];
            default:    misaligned = (offset != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects and extends the addressed byte/half/word of a read word
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  width_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    logic [7:0]  b_sel;
    logic [15:0] h_sel;

    always_comb begin
        b_sel    = rdata_i[{offset_i, 3'b000} +: 8];
        h_sel    = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        result_o = rdata_i;
        case (width_i)
            WIDTH_BYTE: result_o = {{24{~unsigned_i & b_sel[7]}}, b_sel};
            WIDTH_HALF: result_o = {{16{~unsigned_i & h_sel[15]}}, h_sel};
            default:    result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage sequencer for a variable-latency data memory
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  loadWidth,
    input  logic        loadUnsigned,
    input  logic [1:0]  storeWidth,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic        Stall,
    output logic [31:0] ReadData,
    output logic        LoadValid,
    output logic        AlignErr,
    output logic        BusErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  width_q, width_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        load_valid_q, load_valid_d;
    logic        bus_err_q, bus_err_d;

    logic        stall_c, align_err_c;
    logic [1:0]  acc_width;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;
    logic [31:0] aligned_rdata;

    load_align u_load_align (
        .rdata_i    (mem_rdata),
        .offset_i   (off_q),
        .width_i    (width_q),
        .unsigned_i (uns_q),
        .result_o   (aligned_rdata)
    );

    // A simultaneous read+write is a write, so its width rules alignment too.
    always_comb begin
        acc_width  = MemWrite ? storeWidth : loadWidth;
        lane_wdata = WriteData;
        lane_be    = 4'b1111;
        if (MemWrite) begin
            case (storeWidth)
                WIDTH_BYTE: begin
                    lane_wdata = {4{WriteData[7:0]}};
                    lane_be    = 4'b0001 << Address[1:0];
                end
                WIDTH_HALF: begin
                    lane_wdata = {2{WriteData[15:0]}};
                    lane_be    = Address[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    lane_wdata = WriteData;
                    lane_be    = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        width_d      = width_q;
        uns_d        = uns_q;
        off_d        = off_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        req_d        = req_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        load_valid_d = 1'b0;
        bus_err_d    = 1'b0;
        stall_c      = 1'b0;
        align_err_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MemRead | MemWrite) begin
                    if (misaligned(acc_width, Address[1:0])) begin
                        align_err_c = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        we_d    = MemWrite;
                        width_d = acc_width;
                        uns_d   = loadUnsigned;
                        off_d   = Address[1:0];
                        addr_d  = {Address[31:2], 2'b00};
                        wdata_d = lane_wdata;
                        be_d    = lane_be;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                stall_c = 1'b1;
                if (mem_ready) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        rdata_d      = aligned_rdata;
                        load_valid_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        req_d     = 1'b0;
                        rdata_d   = '0;
                        bus_err_d = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            width_q      <= WIDTH_WORD;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            req_q        <= 1'b0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            width_q      <= width_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            req_q        <= req_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            load_valid_q <= load_valid_d;
            bus_err_q    <= bus_err_d;
        end
    end

    // Gating with Rst keeps the pipeline free while reset is held with an access still presented.
    assign Stall     = stall_c & ~Rst;
    assign AlignErr  = align_err_c & ~Rst;
    assign ReadData  = rdata_q;
    assign LoadValid = load_valid_q;
    assign BusErr    = bus_err_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - vector table plus scoreboard bench for dmem_access_ctrl
module tb_dmem_access_ctrl;

    localparam int TIMEOUT = 16;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        MemRead, MemWrite, loadUnsigned;
    logic [1:0]  loadWidth, storeWidth;
    logic [31:0] Address, WriteData;
    logic        Stall, LoadValid, AlignErr, BusErr;
    logic [31:0] ReadData;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(5)) dut (
        .Clk(Clk), .Rst(Rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .loadWidth(loadWidth), .loadUnsigned(loadUnsigned), .storeWidth(storeWidth),
        .Address(Address), .WriteData(WriteData), .Stall(Stall), .ReadData(ReadData),
        .LoadValid(LoadValid), .AlignErr(AlignErr), .BusErr(BusErr), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  lw;
        logic        lu;
        logic [1:0]  sw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic        align;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rd;
    } vec_t;

    vec_t        vecs[$];
    vec_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] last_rd  = 32'h0;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] lw, input logic lu,
                                input logic [1:0] sw, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int delay, input logic align,
                                input logic [31:0] e_addr, input logic [3:0] e_be,
                                input logic [31:0] e_wdata, input logic [31:0] e_rd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.lw = lw; v.lu = lu; v.sw = sw; v.addr = addr;
        v.wdata = wdata; v.rdata = rdata; v.delay = delay; v.align = align;
        v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic clear_inputs();
        MemRead = 0; MemWrite = 0; loadWidth = 0; loadUnsigned = 0;
        storeWidth = 0; Address = 0; WriteData = 0;
    endtask

    task automatic drive(input vec_t v);
        MemRead = v.rd; MemWrite = v.wr; loadWidth = v.lw; loadUnsigned = v.lu;
        storeWidth = v.sw; Address = v.addr; WriteData = v.wdata;
    endtask

    // Called at a falling edge with the FSM in IDLE.
    task automatic run_access(input vec_t v);
        int   waited;
        vec_t e;
        drive(v);
        #1;
        if (v.align) begin
            chk("align_pulse", {31'b0, AlignErr}, 32'd1);
            chk("align_no_stall", {31'b0, Stall}, 32'd0);
            @(negedge Clk);
            chk("align_no_req", {31'b0, mem_req}, 32'd0);
            clear_inputs();
            #1;
            chk("align_cleared", {31'b0, AlignErr}, 32'd0);
            chk("align_readdata_hold", ReadData, last_rd);
            return;
        end
        chk("idle_stall", {31'b0, Stall}, 32'd1);
        sb.push_back(v);
        @(negedge Clk);
        chk("req_addr", mem_addr, v.e_addr);
        chk("req_be", {28'b0, mem_be}, {28'b0, v.e_be});
        chk("req_we", {31'b0, mem_we}, {31'b0, v.wr});
        if (v.wr) chk("req_wdata", mem_wdata, v.e_wdata);
        waited = 0;
        mem_rdata = ~v.rdata;
        while (Stall === 1'b1 && waited < 100) begin
            chk("busy_req", {31'b0, mem_req}, 32'd1);
            if (waited >= v.delay) begin
                mem_ready = 1'b1;
                mem_rdata = v.rdata;
            end
            @(negedge Clk);
            mem_ready = 1'b0;
            mem_rdata = ~v.rdata;
            waited++;
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("stall_cycles", 32'(1 + waited), 32'(2 + e.delay));
        chk("done_loadvalid", {31'b0, LoadValid}, {31'b0, e.rd & ~e.wr});
        if (e.rd && !e.wr) last_rd = e.e_rd;
        chk("done_readdata", ReadData, last_rd);
        chk("done_buserr", {31'b0, BusErr}, 32'd0);
        chk("done_req_low", {31'b0, mem_req}, 32'd0);
        @(negedge Clk);
        chk("no_relaunch", {31'b0, mem_req}, 32'd0);
        chk("loadvalid_pulse", {31'b0, LoadValid}, 32'd0);
        clear_inputs();
    endtask

    initial begin
        int busy;
        Rst = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        clear_inputs();

        vecs.push_back(mk(0,1,2'b00,0,2'b00,32'h10,32'hDEADBEEF,0,0,0,32'h10,4'hF,32'hDEADBEEF,0));
        vecs.push_back(mk(0,1,2'b00,0,2'b10,32'h13,32'h000000A5,0,0,0,32'h10,4'h8,32'hA5A5A5A5,0));
        vecs.push_back(mk(0,1,2'b00,0,2'b01,32'h22,32'h1234BEEF,0,2,0,32'h20,4'hC,32'hBEEFBEEF,0));
        vecs.push_back(mk(0,1,2'b00,0,2'b01,32'h20,32'h0000CAFE,0,1,0,32'h20,4'h3,32'hCAFECAFE,0));
        vecs.push_back(mk(0,1,2'b00,0,2'b10,32'h11,32'h0000003C,0,0,0,32'h10,4'h2,32'h3C3C3C3C,0));
        vecs.push_back(mk(1,0,2'b01,0,2'b00,32'h22,0,32'h80017FFF,1,0,32'h20,4'hF,0,32'hFFFF8001));
        vecs.push_back(mk(1,0,2'b01,1,2'b00,32'h22,0,32'h80017FFF,0,0,32'h20,4'hF,0,32'h00008001));
        vecs.push_back(mk(1,0,2'b01,0,2'b00,32'h20,0,32'h80017FFF,0,0,32'h20,4'hF,0,32'h00007FFF));
        vecs.push_back(mk(1,0,2'b00,0,2'b00,32'h30,0,32'h12345678,3,0,32'h30,4'hF,0,32'h12345678));
        vecs.push_back(mk(0,1,2'b00,0,2'b00,32'h34,32'h0BADF00D,0,0,0,32'h34,4'hF,32'h0BADF00D,0));
        vecs.push_back(mk(1,0,2'b10,1,2'b00,32'h33,0,32'h80A1B2C3,0,0,32'h30,4'hF,0,32'h00000080));
        vecs.push_back(mk(1,0,2'b10,0,2'b00,32'h33,0,32'h80A1B2C3,0,0,32'h30,4'hF,0,32'hFFFFFF80));
        vecs.push_back(mk(1,0,2'b10,0,2'b00,32'h02,0,32'h00550000,0,0,32'h00,4'hF,0,32'h00000055));
        vecs.push_back(mk(1,0,2'b00,0,2'b00,32'h06,0,0,0,1,0,0,0,0));
        vecs.push_back(mk(1,0,2'b01,0,2'b00,32'h21,0,0,0,1,0,0,0,0));
        vecs.push_back(mk(0,1,2'b00,0,2'b00,32'h02,32'h1,0,0,1,0,0,0,0));
        vecs.push_back(mk(1,1,2'b10,0,2'b00,32'h45,32'h1,0,0,1,0,0,0,0));
        vecs.push_back(mk(1,1,2'b10,0,2'b00,32'h44,32'h11223344,0,0,0,32'h44,4'hF,32'h11223344,0));
        vecs.push_back(mk(1,0,2'b11,0,2'b00,32'h48,0,32'hABCD0123,0,0,32'h48,4'hF,0,32'hABCD0123));
        vecs.push_back(mk(1,0,2'b11,0,2'b00,32'h4A,0,0,0,1,0,0,0,0));
        vecs.push_back(mk(0,1,2'b00,0,2'b11,32'h4C,32'h01020304,0,0,0,32'h4C,4'hF,32'h01020304,0));

        #2;
        chk("rst_stall", {31'b0, Stall}, 32'd0);
        chk("rst_loadvalid", {31'b0, LoadValid}, 32'd0);
        chk("rst_alignerr", {31'b0, AlignErr}, 32'd0);
        chk("rst_buserr", {31'b0, BusErr}, 32'd0);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_readdata", ReadData, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_be", {28'b0, mem_be}, 32'h0);
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);

        foreach (vecs[i]) run_access(vecs[i]);

        // Timeout: memory never answers.
        MemRead = 1'b1; loadWidth = 2'b00; Address = 32'h40;
        @(negedge Clk);
        busy = 0;
        while (Stall === 1'b1 && busy < 100) begin
            busy++;
            @(negedge Clk);
        end
        chk("timeout_busy_cycles", 32'(busy), 32'(TIMEOUT));
        chk("timeout_buserr", {31'b0, BusErr}, 32'd1);
        chk("timeout_loadvalid", {31'b0, LoadValid}, 32'd0);
        chk("timeout_readdata", ReadData, 32'h0);
        chk("timeout_req_low", {31'b0, mem_req}, 32'd0);
        last_rd = 32'h0;
        @(negedge Clk);
        chk("timeout_buserr_pulse", {31'b0, BusErr}, 32'd0);
        chk("timeout_no_relaunch", {31'b0, mem_req}, 32'd0);
        clear_inputs();

        // Reset while BUSY with the load still presented.
        MemRead = 1'b1; loadWidth = 2'b00; Address = 32'h50;
        @(negedge Clk);
        chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
        #2 Rst = 1'b1;
        #1;
        chk("async_rst_req", {31'b0, mem_req}, 32'd0);
        chk("async_rst_stall", {31'b0, Stall}, 32'd0);
        @(negedge Clk);
        clear_inputs();
        Rst = 1'b0;
        last_rd = 32'h0;
        run_access(mk(1,0,2'b10,0,2'b00,32'h01,0,32'h0000FF00,0,0,32'h00,4'hF,0,32'hFFFFFFFF));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences every data-memory access issued by the MEM pipeline stage against a data memory that answers with a variable-latency ready handshake.
- Latches the request, drives word-aligned address, write data and byte enables, and holds the pipeline with Stall until the memory answers.
- Returns load data aligned and sign- or zero-extended for write-back.
- Sits between the EX/MEM pipeline register, which carries MemRead, MemWrite, loadWidth, loadUnsigned and storeWidth from the main controller, and the data memory.

Parameters:
- TIMEOUT_CYCLES, 16: maximum BUSY cycles to wait for mem_ready before aborting. Must be >= 1.
- CNT_W, 5: width of the wait counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- MemRead  in  1  load in MEM stage.
- MemWrite  in  1  store in MEM stage.
- loadWidth  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word).
- loadUnsigned  in  1  1 = zero-extend sub-word load.
- storeWidth  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word).
- Address  in  32  byte address from the ALU.
- WriteData  in  32  store data, right-justified.
- Stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- ReadData  out  32  aligned, extended load result.
- LoadValid  out  1  ReadData valid this cycle.
- AlignErr  out  1  one-cycle pulse: misaligned access, dropped.
- BusErr  out  1  one-cycle pulse: memory timeout.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  1 = write.
- mem_addr  out  32  Address with bits [1:0] forced to 00.
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables; bit i = bits 8i+7:8i (little-endian).
- mem_ready  in  1  memory accepted the write / rdata valid.
- mem_rdata  in  32  read word.

Behaviour:
- Clocking and reset: one clock Clk; reset Rst is asynchronous, active-high.
- Reset values: state IDLE; Stall, LoadValid, AlignErr, BusErr, mem_req and mem_we all 0; ReadData, mem_addr, mem_wdata, mem_be and the wait counter all 0.
- Reset asserted mid-access drops mem_req immediately and abandons the access; no memory-side cleanup is performed.
- Access detection: access = MemRead | MemWrite. If both are high, it is treated as a write.
- Alignment check:
  - Half access is misaligned when Address[0] = 1.
  - Word access is misaligned when Address[1:0] != 00.
- State IDLE:
  - Aligned access: Stall = 1 combinationally in the same cycle. At the clock edge, latch we, width, unsigned flag, Address[1:0], mem_addr, mem_wdata and mem_be; set mem_req = 1 and clear the counter; go to BUSY.
  - Misaligned access: AlignErr = 1 combinationally for that cycle; Stall = 0; stay in IDLE; no memory traffic.
  - No access: idle; all pulse outputs 0.
- State BUSY:
  - Stall = 1. mem_req, mem_we, mem_addr, mem_wdata and mem_be stay stable.
  - mem_ready = 1: register the aligned load result (reads) into ReadData; drop mem_req; go to DONE.
  - Otherwise the counter increments each cycle. When it reaches TIMEOUT_CYCLES without mem_ready: drop mem_req, set ReadData = 0, BusErr = 1 for one cycle (registered), go to DONE.
- State DONE:
  - Stall = 0, so the pipeline advances at the end of this cycle.
  - LoadValid = 1 if the latched op was a read and no timeout occurred.
  - Inputs are ignored; the same instruction is still presented and must not relaunch.
  - Always return to IDLE.
- Latency: minimum 3 cycles per access (IDLE, BUSY with mem_ready=1, DONE), i.e. 2 stall cycles. Each extra wait cycle adds one.
- Store lanes:
  - Byte: wdata = {4{WriteData[7:0]}}; be = 0001 shifted left by Address[1:0].
  - Half: wdata = {2{WriteData[15:0]}}; be = 0011 when Address[1] = 0, 1100 when Address[1] = 1.
  - Word: wdata = WriteData; be = 1111.
  - Reads drive be = 1111.
- Load extract:
  - Byte: select the byte at offset, sign- or zero-extend per loadUnsigned.
  - Half: select half [15:0] or [31:16] by offset bit 1, then extend.
  - Word: pass mem_rdata through.
- ReadData holds its value until the next completed load.

Decomposition:
- Shared package dmem_pkg holds:
  - width encodings WIDTH_WORD=2'b00, WIDTH_HALF=2'b01, WIDTH_BYTE=2'b10;
  - state encodings ST_IDLE, ST_BUSY, ST_DONE (2 bits).
  - The main controller adopts the width constants from the same package.
- Sub-module load_align: combinational; inputs rdata, offset[1:0], width, unsigned; output the extended 32-bit result. It is reusable by any future cache fill path.

Test Plan:
- Store word: Address=0x10, WriteData=0xDEADBEEF, mem_ready high 1 cycle after mem_req -> mem_addr=0x10, be=1111, wdata=0xDEADBEEF; Stall high exactly 2 cycles.
- Store byte: Address=0x13, WriteData=0x000000A5 -> be=1000, wdata=0xA5A5A5A5, mem_we=1.
- Load half signed/unsigned: mem_rdata=0x8001_7FFF at Address=0x22 -> ReadData=0xFFFF8001 (signed), 0x00008001 (unsigned). At Address=0x20 -> 0x00007FFF.
- Misaligned: lw at Address=0x06 -> AlignErr pulses 1 cycle, mem_req never asserted, Stall=0.
- Timeout: mem_ready held 0 -> BusErr pulse after TIMEOUT_CYCLES BUSY cycles, ReadData=0, LoadValid=0, FSM back to IDLE.
- Reset during BUSY: assert Rst with mem_req=1 -> mem_req and Stall drop immediately without waiting for a clock edge; after release, a new lb at 0x01 with rdata=0x0000FF00 -> ReadData=0xFFFFFFFF.
